video_line_scaler: RTL

VIDEO_LINE_SCALER -- requirements
Module: video_line_scaler

---
 rtl/video_line_scaler_pkg.sv | 23 ++
 rtl/video_line_scaler_if.sv | 41 ++++
 rtl/video_line_scaler_sdp_ram.sv | 23 ++
 rtl/video_line_scaler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/video_line_scaler_pkg.sv
// Shared defaults, phase-step fixed-point format and aspect-mode encoding
// for the video line scaler.
package video_scaler_pkg;
  localparam int DEF_CH    = 3;
  localparam int DEF_DW    = 8;
  localparam int DEF_LINES = 4;
  localparam int DEF_MAX_W = 2048;
  localparam int DEF_OUT_W = 1280;
  localparam int DEF_BAR_W = 160;
  localparam int DEF_PW    = 16;

  // Step is unsigned fixed point with this many integer bits.
  localparam int STEP_INT_BITS = 4;

  typedef enum logic {
    MODE_16_9 = 1'b0,
    MODE_4_3  = 1'b1
  } aspect_mode_e;

  function automatic int step_frac_bits(input int pw);
    return pw - STEP_INT_BITS;
  endfunction
endpackage

// File: rtl/video_line_scaler_if.sv
// Input-line and output-line video signals of the scaler; the source/timing
// side uses the master modport, the scaler the slave modport.
interface video_line_scaler_if
  import video_scaler_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int DW    = DEF_DW,
  parameter int PW    = DEF_PW,
  parameter int MAX_W = DEF_MAX_W
);
  localparam int WW = $clog2(MAX_W) + 1;

  logic            i_in_sol;
  logic            i_in_vsync;
  logic            i_in_valid;
  logic [CH*DW-1:0] i_in_data;
  logic            i_out_sol;
  logic            i_out_de;
  logic            i_four_three;
  logic [PW-1:0]   i_step;
  logic [CH*DW-1:0] o_out_data;
  logic            o_out_valid;
  logic [WW-1:0]   o_in_width;
  logic            o_frame_end;
  logic            o_overflow;
  logic            o_underflow;

  modport master (
    output i_in_sol, i_in_vsync, i_in_valid, i_in_data,
           i_out_sol, i_out_de, i_four_three, i_step,
    input  o_out_data, o_out_valid, o_in_width, o_frame_end,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_in_sol, i_in_vsync, i_in_valid, i_in_data,
           i_out_sol, i_out_de, i_four_three, i_step,
    output o_out_data, o_out_valid, o_in_width, o_frame_end,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/video_line_scaler_sdp_ram.sv
// Simple dual-port line-buffer storage: one write port, one registered read
// port, no reset so it maps onto block RAM.
module sdp_ram
  import video_scaler_pkg::*;
#(
  parameter int DEPTH = DEF_LINES * DEF_MAX_W,
  parameter int WIDTH = DEF_CH * DEF_DW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/video_line_scaler.sv
// Horizontal nearest-neighbour line scaler: input lines land in a ring of
// line slots, output lines resample the oldest committed slot.
module video_line_scaler
  import video_scaler_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int DW    = DEF_DW,
  parameter int LINES = DEF_LINES,
  parameter int MAX_W = DEF_MAX_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int BAR_W = DEF_BAR_W,
  parameter int PW    = DEF_PW
) (
  input logic                clk,
  input logic                i_rst_n,
  video_line_scaler_if.slave bus
);
  localparam int DATA_W = CH * DW;
  localparam int AW     = $clog2(MAX_W);
  localparam int WW     = AW + 1;
  localparam int SW     = $clog2(LINES);
  localparam int RAW    = SW + AW;
  localparam int FRAC   = step_frac_bits(PW);
  localparam int ACC_W  = WW + FRAC;
  localparam int XW     = $clog2(OUT_W + 1);
  localparam logic [SW:0]   FILL_MAX = (SW+1)'(LINES - 1);
  localparam logic [XW-1:0] X_END    = XW'(OUT_W);
  localparam logic [XW-1:0] BAR_LO   = XW'(BAR_W);
  localparam logic [XW-1:0] BAR_HI   = XW'(OUT_W - BAR_W);

  logic [WW-1:0]     col;
  logic [SW-1:0]     wr_slot, rd_slot;
  logic [SW:0]       fill;
  logic [WW-1:0]     in_width;
  logic              overflow, underflow;
  logic              commit_req, commit_ok, consume_ok, wr_en;
  logic [RAW-1:0]    wr_addr, rd_addr;

  logic [XW-1:0]     x;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_sum;
  logic [PW-1:0]     step_l;
  aspect_mode_e      mode_l;
  logic [WW-1:0]     width_l, last_col, acc_int, sample_col;
  logic              in_window;
  logic              v1, zero1, out_valid;
  logic [DATA_W-1:0] ram_q, out_data;
  logic              vsync_q, vsync_qq, frame_end;

  assign commit_req = bus.i_in_sol && (col != '0);
  assign commit_ok  = commit_req && (fill != FILL_MAX);
  assign consume_ok = bus.i_out_sol && (fill != '0);
  // When the ring is full the write slot aliases the displayed slot; such a
  // line is going to be dropped anyway, so keep the displayed line intact.
  assign wr_en   = bus.i_in_valid && !bus.i_in_sol && !col[AW] && (wr_slot != rd_slot);
  assign wr_addr = {wr_slot, AW'(col)};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col       <= '0;
      wr_slot   <= SW'(1);
      rd_slot   <= '0;
      fill      <= '0;
      in_width  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= commit_req && !commit_ok;
      underflow <= bus.i_out_sol && (fill == '0);
      if (bus.i_in_sol)                   col <= '0;
      else if (bus.i_in_valid && !col[AW]) col <= col + 1'b1;
      if (commit_ok) begin
        wr_slot  <= wr_slot + 1'b1;
        in_width <= col;
      end
      if (consume_ok) rd_slot <= rd_slot + 1'b1;
      case ({commit_ok, consume_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_comb begin
    in_window = (x < X_END);
    if (mode_l == MODE_4_3) in_window = (x >= BAR_LO) && (x < BAR_HI);
  end

  assign acc_sum    = {1'b0, acc} + {{(ACC_W + 1 - PW){1'b0}}, step_l};
  assign acc_int    = acc[ACC_W-1:FRAC];
  assign last_col   = width_l - 1'b1;
  assign sample_col = (acc_int > last_col) ? last_col : acc_int;
  assign rd_addr    = {rd_slot, AW'(sample_col)};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x         <= '0;
      acc       <= '0;
      step_l    <= '0;
      mode_l    <= MODE_16_9;
      width_l   <= '0;
      v1        <= 1'b0;
      zero1     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (bus.i_out_sol) begin
        x       <= '0;
        acc     <= '0;
        step_l  <= bus.i_step;
        mode_l  <= aspect_mode_e'(bus.i_four_three);
        width_l <= in_width;
      end else if (bus.i_out_de) begin
        if (x != X_END) x <= x + 1'b1;
        if (in_window)  acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      end
      // Stage 1 is the RAM read; stage 2 applies the blanking decision.
      v1        <= bus.i_out_de;
      zero1     <= !in_window || (width_l == '0);
      out_valid <= v1;
      out_data  <= zero1 ? '0 : ram_q;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q   <= 1'b1;
      vsync_qq  <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      vsync_q   <= bus.i_in_vsync;
      vsync_qq  <= vsync_q;
      frame_end <= vsync_qq && !vsync_q;
    end
  end

  sdp_ram #(.DEPTH(LINES * MAX_W), .WIDTH(DATA_W), .AW(RAW)) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.i_in_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign bus.o_out_data  = out_data;
  assign bus.o_out_valid = out_valid;
  assign bus.o_in_width  = in_width;
  assign bus.o_frame_end = frame_end;
  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
endmodule
